// File: rtl/cpu_pkg.sv
// Shared opcodes, control-word layout and sequencer defaults
// for the 4-bit-address CPU.
package cpu_pkg;

  localparam int CW_WIDTH      = 16;
  localparam int STEPS_DEFAULT = 5;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CW_HLT = 15;
  localparam int CW_MI  = 14;
  localparam int CW_RI  = 13;
  localparam int CW_RO  = 12;
  localparam int CW_II  = 11;
  localparam int CW_IO  = 10;
  localparam int CW_AI  = 9;
  localparam int CW_AO  = 8;
  localparam int CW_BI  = 7;
  localparam int CW_EO  = 6;
  localparam int CW_SU  = 5;
  localparam int CW_FI  = 4;
  localparam int CW_OI  = 3;
  localparam int CW_CE  = 2;
  localparam int CW_CO  = 1;
  localparam int CW_J   = 0;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: control word for one opcode/step/flags.
// Steps beyond T4 are always empty.
module microcode_rom
  import cpu_pkg::*;
(
  input  logic [3:0]          opcode,
  input  logic [2:0]          step,
  input  logic                c,
  input  logic                z,
  output logic [CW_WIDTH-1:0] cw
);

  always_comb begin
    cw = '0;
    case (step)
      3'd0: begin
        cw[CW_CO] = 1'b1;
        cw[CW_MI] = 1'b1;
      end
      3'd1: begin
        cw[CW_RO] = 1'b1;
        cw[CW_II] = 1'b1;
        cw[CW_CE] = 1'b1;
      end
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IO] = 1'b1;
            cw[CW_MI] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IO] = 1'b1;
            cw[CW_AI] = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IO] = 1'b1;
            cw[CW_J]  = 1'b1;
          end
          OP_JC: begin
            cw[CW_IO] = c;
            cw[CW_J]  = c;
          end
          OP_JZ: begin
            cw[CW_IO] = z;
            cw[CW_J]  = z;
          end
          OP_OUT: begin
            cw[CW_AO] = 1'b1;
            cw[CW_OI] = 1'b1;
          end
          OP_HLT: cw[CW_HLT] = 1'b1;
          default: ;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA: begin
            cw[CW_RO] = 1'b1;
            cw[CW_AI] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RO] = 1'b1;
            cw[CW_BI] = 1'b1;
          end
          OP_STA: begin
            cw[CW_AO] = 1'b1;
            cw[CW_RI] = 1'b1;
          end
          default: ;
        endcase
      end
      3'd4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw[CW_EO] = 1'b1;
          cw[CW_AI] = 1'b1;
          cw[CW_FI] = 1'b1;
          cw[CW_SU] = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer: step/halt registers, early instruction end,
// and fan-out of the microcode word to the CPU control lines.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int STEPS     = STEPS_DEFAULT,
  parameter bit EARLY_END = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_opcode,
  input  logic       i_flag_c,
  input  logic       i_flag_z,
  output logic       o_hlt,
  output logic       o_mi,
  output logic       o_ri,
  output logic       o_ro,
  output logic       o_ii,
  output logic       o_io,
  output logic       o_ai,
  output logic       o_ao,
  output logic       o_bi,
  output logic       o_eo,
  output logic       o_su,
  output logic       o_fi,
  output logic       o_oi,
  output logic       o_ce,
  output logic       o_co,
  output logic       o_j,
  output logic [2:0] o_step,
  output logic       o_halted
);

  logic [2:0]          step_q;
  logic [2:0]          step_d;
  logic                halted_q;
  logic                halt_now;
  logic                tail_nz;
  logic                last;
  logic                early;
  logic [CW_WIDTH-1:0] cw_cur;
  logic [CW_WIDTH-1:0] cw_out;
  logic [CW_WIDTH-1:0] words [STEPS];

  // One ROM per T-state so the remaining steps can be inspected at once
  for (genvar s = 0; s < STEPS; s++) begin : g_rom
    microcode_rom u_rom (
      .opcode (i_opcode),
      .step   (3'(s)),
      .c      (i_flag_c),
      .z      (i_flag_z),
      .cw     (words[s])
    );
  end

  always_comb begin
    cw_cur  = '0;
    tail_nz = 1'b0;
    for (int s = 0; s < STEPS; s++) begin
      if (step_q == 3'(s)) cw_cur = words[s];
      if (3'(s) > step_q && |words[s]) tail_nz = 1'b1;
    end
  end

  // Opcode is only valid from T2, so early end is never taken in fetch
  always_comb begin
    halt_now = cw_cur[CW_HLT];
    last     = (step_q == 3'(STEPS - 1));
    early    = EARLY_END && (step_q >= 3'd2) && !tail_nz;
    step_d   = (last || early) ? 3'd0 : step_q + 3'd1;
    if (halt_now) step_d = step_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      step_q   <= step_d;
      halted_q <= halt_now;
    end
  end

  always_comb begin
    cw_out = cw_cur;
    if (i_rst) begin
      cw_out = '0;
    end else if (halted_q) begin
      cw_out         = '0;
      cw_out[CW_HLT] = 1'b1;
    end
  end

  assign o_hlt    = cw_out[CW_HLT];
  assign o_mi     = cw_out[CW_MI];
  assign o_ri     = cw_out[CW_RI];
  assign o_ro     = cw_out[CW_RO];
  assign o_ii     = cw_out[CW_II];
  assign o_io     = cw_out[CW_IO];
  assign o_ai     = cw_out[CW_AI];
  assign o_ao     = cw_out[CW_AO];
  assign o_bi     = cw_out[CW_BI];
  assign o_eo     = cw_out[CW_EO];
  assign o_su     = cw_out[CW_SU];
  assign o_fi     = cw_out[CW_FI];
  assign o_oi     = cw_out[CW_OI];
  assign o_ce     = cw_out[CW_CE];
  assign o_co     = cw_out[CW_CO];
  assign o_j      = cw_out[CW_J];
  assign o_step   = i_rst ? 3'd0 : step_q;
  assign o_halted = halted_q && !i_rst;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: early-end and fixed-length
// instances share stimulus.
module tb_control_sequencer;

  localparam logic [15:0] H  = 16'h8000;
  localparam logic [15:0] MI = 16'h4000;
  localparam logic [15:0] RI = 16'h2000;
  localparam logic [15:0] RO = 16'h1000;
  localparam logic [15:0] II = 16'h0800;
  localparam logic [15:0] IO = 16'h0400;
  localparam logic [15:0] AI = 16'h0200;
  localparam logic [15:0] AO = 16'h0100;
  localparam logic [15:0] BI = 16'h0080;
  localparam logic [15:0] EO = 16'h0040;
  localparam logic [15:0] SU = 16'h0020;
  localparam logic [15:0] FI = 16'h0010;
  localparam logic [15:0] OI = 16'h0008;
  localparam logic [15:0] CE = 16'h0004;
  localparam logic [15:0] CO = 16'h0002;
  localparam logic [15:0] J  = 16'h0001;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       fc;
  logic       fz;

  logic hlt, mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi, ce, co, j;
  logic [2:0] step;
  logic halted;
  logic f_hlt, f_mi, f_ri, f_ro, f_ii, f_io, f_ai, f_ao;
  logic f_bi, f_eo, f_su, f_fi, f_oi, f_ce, f_co, f_j;
  logic [2:0] f_step;
  logic f_halted;

  int checks = 0;
  int passes = 0;

  wire [15:0] cw = {hlt, mi, ri, ro, ii, io, ai, ao,
                    bi, eo, su, fi, oi, ce, co, j};
  wire [15:0] f_cw = {f_hlt, f_mi, f_ri, f_ro, f_ii, f_io, f_ai, f_ao,
                      f_bi, f_eo, f_su, f_fi, f_oi, f_ce, f_co, f_j};

  always #5 clk = ~clk;

  control_sequencer #(.STEPS(5), .EARLY_END(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode),
    .i_flag_c(fc), .i_flag_z(fz),
    .o_hlt(hlt), .o_mi(mi), .o_ri(ri), .o_ro(ro),
    .o_ii(ii), .o_io(io), .o_ai(ai), .o_ao(ao),
    .o_bi(bi), .o_eo(eo), .o_su(su), .o_fi(fi),
    .o_oi(oi), .o_ce(ce), .o_co(co), .o_j(j),
    .o_step(step), .o_halted(halted)
  );

  control_sequencer #(.STEPS(5), .EARLY_END(1'b0)) dut_fixed (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode),
    .i_flag_c(fc), .i_flag_z(fz),
    .o_hlt(f_hlt), .o_mi(f_mi), .o_ri(f_ri), .o_ro(f_ro),
    .o_ii(f_ii), .o_io(f_io), .o_ai(f_ai), .o_ao(f_ao),
    .o_bi(f_bi), .o_eo(f_eo), .o_su(f_su), .o_fi(f_fi),
    .o_oi(f_oi), .o_ce(f_ce), .o_co(f_co), .o_j(f_j),
    .o_step(f_step), .o_halted(f_halted)
  );

  task automatic test_reset();
    rst = 1'b1;
    opcode = 4'h0;
    fc = 1'b0;
    fz = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (cw !== 16'h0 || step !== 3'd0 || halted !== 1'b0)
      $display("FAIL reset_hold cw=%h step=%0d halted=%b want 0000/0/0",
               cw, step, halted);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (cw !== (CO | MI) || step !== 3'd0)
      $display("FAIL reset_t0 cw=%h step=%0d want %h/0", cw, step, CO | MI);
    else passes++;
  endtask

  task automatic test_basic_ops();
    logic [3:0]  ops [7] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'hE, 4'hB};
    int          lens [7] = '{3, 4, 4, 3, 3, 3, 3};
    logic [15:0] w2 [7] = '{16'h0, IO | MI, IO | MI, IO | AI,
                            IO | J, AO | OI, 16'h0};
    logic [15:0] w3 [7] = '{16'h0, RO | AI, AO | RI, 16'h0,
                            16'h0, 16'h0, 16'h0};
    logic [15:0] w [4];
    for (int t = 0; t < 7; t++) begin
      opcode = ops[t];
      fc = 1'b0;
      fz = 1'b0;
      w[0] = CO | MI;
      w[1] = RO | II | CE;
      w[2] = w2[t];
      w[3] = w3[t];
      for (int k = 0; k < lens[t]; k++) begin
        #1;
        checks++;
        if (step !== 3'(k) || cw !== w[k])
          $display("FAIL basic op=%h k=%0d got step=%0d cw=%h want step=%0d cw=%h",
                   ops[t], k, step, cw, k, w[k]);
        else passes++;
        @(negedge clk);
      end
      #1;
      checks++;
      if (step !== 3'd0)
        $display("FAIL basic_end op=%h got step=%0d want 0", ops[t], step);
      else passes++;
    end
  endtask

  task automatic test_add_sub();
    logic [15:0] w [5];
    for (int v = 0; v < 2; v++) begin
      opcode = (v == 1) ? 4'h3 : 4'h2;
      w[0] = CO | MI;
      w[1] = RO | II | CE;
      w[2] = IO | MI;
      w[3] = RO | BI;
      w[4] = EO | AI | FI | ((v == 1) ? SU : 16'h0);
      for (int k = 0; k < 5; k++) begin
        #1;
        checks++;
        if (step !== 3'(k) || cw !== w[k])
          $display("FAIL add_sub op=%h k=%0d got step=%0d cw=%h want step=%0d cw=%h",
                   opcode, k, step, cw, k, w[k]);
        else passes++;
        @(negedge clk);
      end
      #1;
      checks++;
      if (step !== 3'd0)
        $display("FAIL add_sub_wrap op=%h got step=%0d want 0", opcode, step);
      else passes++;
    end
  endtask

  task automatic test_jumps();
    logic [3:0] ops [4] = '{4'h7, 4'h7, 4'h8, 4'h8};
    logic       cs [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       zs [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       tk [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] w [3];
    for (int t = 0; t < 4; t++) begin
      opcode = ops[t];
      fc = cs[t];
      fz = zs[t];
      w[0] = CO | MI;
      w[1] = RO | II | CE;
      w[2] = tk[t] ? (IO | J) : 16'h0;
      for (int k = 0; k < 3; k++) begin
        #1;
        checks++;
        if (step !== 3'(k) || cw !== w[k])
          $display("FAIL jump op=%h c=%b z=%b k=%0d got step=%0d cw=%h want step=%0d cw=%h",
                   ops[t], cs[t], zs[t], k, step, cw, k, w[k]);
        else passes++;
        @(negedge clk);
      end
      #1;
      checks++;
      if (step !== 3'd0)
        $display("FAIL jump_end op=%h got step=%0d want 0", ops[t], step);
      else passes++;
    end
    fc = 1'b0;
    fz = 1'b0;
  endtask

  task automatic test_halt();
    logic [15:0] w [3];
    opcode = 4'hF;
    w[0] = CO | MI;
    w[1] = RO | II | CE;
    w[2] = H;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (step !== 3'(k) || cw !== w[k] || halted !== 1'b0)
        $display("FAIL hlt_seq k=%0d got step=%0d cw=%h halted=%b want step=%0d cw=%h halted=0",
                 k, step, cw, halted, k, w[k]);
      else passes++;
      @(negedge clk);
    end
    for (int n = 0; n < 20; n++) begin
      #1;
      checks++;
      if (cw !== H || step !== 3'd2 || halted !== 1'b1)
        $display("FAIL halted n=%0d got cw=%h step=%0d halted=%b want %h/2/1",
                 n, cw, step, halted, H);
      else passes++;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cw !== 16'h0 || step !== 3'd0 || halted !== 1'b0)
      $display("FAIL hlt_rst_hold got cw=%h step=%0d halted=%b want 0000/0/0",
               cw, step, halted);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    opcode = 4'h0;
    #1;
    checks++;
    if (cw !== (CO | MI) || step !== 3'd0 || halted !== 1'b0)
      $display("FAIL hlt_cleared got cw=%h step=%0d halted=%b want %h/0/0",
               cw, step, halted, CO | MI);
    else passes++;
  endtask

  task automatic test_reset_mid();
    opcode = 4'h1;
    for (int k = 0; k < 3; k++) @(negedge clk);
    #1;
    checks++;
    if (step !== 3'd3 || cw !== (RO | AI))
      $display("FAIL lda_t3 got step=%0d cw=%h want 3/%h", step, cw, RO | AI);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if (cw !== 16'h0 || step !== 3'd0)
      $display("FAIL mid_rst_hold got cw=%h step=%0d want 0000/0", cw, step);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (cw !== (CO | MI) || step !== 3'd0)
      $display("FAIL mid_rst_t0 got cw=%h step=%0d want %h/0", cw, step, CO | MI);
    else passes++;
  endtask

  task automatic test_fixed();
    logic ok;
    int   bad_k;
    rst = 1'b1;
    fc = 1'b0;
    fz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int op = 0; op < 15; op++) begin
      opcode = 4'(op);
      ok = 1'b1;
      bad_k = -1;
      for (int k = 0; k < 5; k++) begin
        #1;
        if (f_step !== 3'(k) && ok) begin
          ok = 1'b0;
          bad_k = k;
        end
        if (k >= 3 && op != 1 && op != 2 && op != 3 && op != 4
            && f_cw !== 16'h0 && ok) begin
          ok = 1'b0;
          bad_k = k;
        end
        @(negedge clk);
      end
      #1;
      if (f_step !== 3'd0 && ok) begin
        ok = 1'b0;
        bad_k = 5;
      end
      checks++;
      if (!ok)
        $display("FAIL fixed_len op=%h at cycle %0d got step=%0d cw=%h want 5-cycle sequence",
                 op, bad_k, f_step, f_cw);
      else passes++;
    end
  endtask

  task automatic test_random();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      opcode = 4'($urandom_range(0, 15));
      fc = 1'($urandom_range(0, 1));
      fz = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 63) == 0);
      #1;
      checks++;
      if ($countones({co, ro, io, ao, eo}) > 1 || (ce && j))
        $display("FAIL bus_early n=%0d co=%b ro=%b io=%b ao=%b eo=%b ce=%b j=%b want <=1 driver, not ce&j",
                 n, co, ro, io, ao, eo, ce, j);
      else passes++;
      checks++;
      if ($countones({f_co, f_ro, f_io, f_ao, f_eo}) > 1 || (f_ce && f_j))
        $display("FAIL bus_fixed n=%0d co=%b ro=%b io=%b ao=%b eo=%b ce=%b j=%b want <=1 driver, not ce&j",
                 n, f_co, f_ro, f_io, f_ao, f_eo, f_ce, f_j);
      else passes++;
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_add_sub();
    test_jumps();
    test_halt();
    test_reset_mid();
    test_fixed();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
